// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sweep checker and its golden model:
// opcode values, condition-code bit positions and checker FSM states.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;
  localparam int CCR_W  = 2;
  localparam int ERR_W  = 9;

  // Condition-code bit indices within alu_ccr
  localparam int CCR_C = 1;  // carry / borrow / shifted-out bit
  localparam int CCR_V = 0;  // two's-complement overflow

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_sweep_checker_if.sv
// Bus between the sweep checker and the ALU under test. The checker is the
// master (drives operands and operator); the ALU is the slave (returns
// result and flags).
interface alu_sweep_checker_if
  import alu_pkg::*;
  ;

  logic [DATA_W-1:0] alu_n1;
  logic [DATA_W-1:0] alu_n2;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic [CCR_W-1:0]  alu_ccr;

  modport master (
    output alu_n1, alu_n2, alu_op,
    input  alu_result, alu_ccr
  );

  modport slave (
    input  alu_n1, alu_n2, alu_op,
    output alu_result, alu_ccr
  );

endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden 4-bit ALU. Results are modulo 16; carry and overflow
// are produced only by the operators that define them, all other flags are 0.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] n1_i,
  input  logic [DATA_W-1:0] n2_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] result_o,
  output logic [CCR_W-1:0]  ccr_o
);

  logic [DATA_W:0]          add_w;
  logic [DATA_W:0]          sub_w;
  logic signed [DATA_W-1:0] n1_s;
  logic signed [DATA_W-1:0] n2_s;
  logic signed [DATA_W:0]   add_s;
  logic signed [DATA_W:0]   sub_s;
  logic                     add_ovf;
  logic                     sub_ovf;

  // Unsigned one-bit-wider sums expose carry/borrow in the top bit
  assign add_w = {1'b0, n1_i} + {1'b0, n2_i};
  assign sub_w = {1'b0, n1_i} - {1'b0, n2_i};

  // Signed overflow: the 5-bit exact result does not fit back in 4 bits
  assign n1_s    = n1_i;
  assign n2_s    = n2_i;
  assign add_s   = n1_s + n2_s;
  assign sub_s   = n1_s - n2_s;
  assign add_ovf = add_s[DATA_W] ^ add_s[DATA_W-1];
  assign sub_ovf = sub_s[DATA_W] ^ sub_s[DATA_W-1];

  // Operator decode; flags default to 0 for the logical operators
  always_comb begin
    result_o = '0;
    ccr_o    = '0;
    case (op_i)
      OP_ADD: begin
        result_o     = add_w[DATA_W-1:0];
        ccr_o[CCR_C] = add_w[DATA_W];
        ccr_o[CCR_V] = add_ovf;
      end
      OP_SUB: begin
        result_o     = sub_w[DATA_W-1:0];
        ccr_o[CCR_C] = sub_w[DATA_W];
        ccr_o[CCR_V] = sub_ovf;
      end
      OP_AND: result_o = n1_i & n2_i;
      OP_OR:  result_o = n1_i | n2_i;
      OP_XOR: result_o = n1_i ^ n2_i;
      OP_NOT: result_o = ~n1_i;
      OP_SHL: begin
        result_o     = {n1_i[DATA_W-2:0], 1'b0};
        ccr_o[CCR_C] = n1_i[DATA_W-1];
      end
      OP_SHR: begin
        result_o     = {1'b0, n1_i[DATA_W-1:1]};
        ccr_o[CCR_C] = n1_i[0];
      end
      default: begin
        result_o = '0;
        ccr_o    = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sweep_checker.sv
// Exhaustive ALU checker: on start, sweeps all 256 (n1, n2) operand pairs
// for one latched operator, holds each pair SETTLE_CYCLES cycles, then
// compares the ALU response with the golden model for one cycle. Reports
// mismatch count, pass flag and the operands of the first mismatch.
module alu_sweep_checker
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OP_W-1:0]     op,
  alu_sweep_checker_if.master alu,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [DATA_W-1:0]   first_err_n1,
  output logic [DATA_W-1:0]   first_err_n2
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = 9'd256;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   n1_q, n1_d;
  logic [DATA_W-1:0]   n2_q, n2_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [DATA_W-1:0]   fe1_q, fe1_d;
  logic [DATA_W-1:0]   fe2_q, fe2_d;

  logic [DATA_W-1:0]   gold_res;
  logic [CCR_W-1:0]    gold_ccr;
  logic                mismatch;
  logic                last_vec;

  alu_ref_model u_ref (
    .n1_i     (n1_q),
    .n2_i     (n2_q),
    .op_i     (op_q),
    .result_o (gold_res),
    .ccr_o    (gold_ccr)
  );

  assign mismatch = {alu.alu_result, alu.alu_ccr} != {gold_res, gold_ccr};
  assign last_vec = (n1_q == 4'hF) && (n2_q == 4'hF);

  // State, operand and result registers; reset clears every output at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
      op_q    <= '0;
      err_q   <= '0;
      fe1_q   <= '0;
      fe2_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      op_q    <= op_d;
      err_q   <= err_d;
      fe1_q   <= fe1_d;
      fe2_q   <= fe2_d;
    end
  end

  // Sweep sequencing: settle, compare, advance n2 fastest, stop after (15,15)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    op_d    = op_q;
    err_d   = err_q;
    fe1_d   = fe1_q;
    fe2_d   = fe2_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          n1_d    = '0;
          n2_d    = '0;
          op_d    = op;
          err_d   = '0;
          fe1_d   = '0;
          fe2_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err_q == '0) begin
            fe1_d = n1_q;
            fe2_d = n2_q;
          end
          if (err_q != ERR_MAX) begin
            err_d = err_q + 9'd1;
          end
        end
        if (last_vec) begin
          state_d = ST_DONE;
        end else begin
          {n1_d, n2_d} = {n1_q, n2_q} + 8'd1;
          state_d      = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy         = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done         = (state_q == ST_DONE);
  assign pass         = done && (err_q == '0);
  assign err_count    = err_q;
  assign first_err_n1 = fe1_q;
  assign first_err_n2 = fe2_q;

  assign alu.alu_n1 = n1_q;
  assign alu.alu_n2 = n2_q;
  assign alu.alu_op = op_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Bench for alu_sweep_checker: a behavioural ALU with selectable faults sits
// on the slave side of the bus; expected sweep outcomes come from an
// integer-arithmetic model of the ALU rules.
module tb_alu_sweep_checker;
  import alu_pkg::*;

  localparam int SC      = 1;
  localparam int BUSY_N  = 256 * (SC + 1);
  localparam int TIMEOUT = BUSY_N + 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic        busy, done, pass;
  logic [8:0]  err_count;
  logic [3:0]  fe1, fe2;

  int           fault_mode;
  logic [255:0] fault_mask;

  int n_cmp = 0;
  int n_bad = 0;

  alu_sweep_checker_if bus ();

  alu_sweep_checker #(.SETTLE_CYCLES(SC)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .alu          (bus.master),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .first_err_n1 (fe1),
    .first_err_n2 (fe2)
  );

  always #5 clk = ~clk;

  // Golden response {result[3:0], carry, overflow} from plain integer arithmetic
  function automatic logic [5:0] gold(input int a, input int b, input int o);
    int   r, s, sa, sb;
    logic c, v;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    r = 0; c = 1'b0; v = 1'b0;
    case (o)
      0: begin s = a + b; r = s % 16; c = (s >= 16); v = ((sa + sb) > 7) || ((sa + sb) < -8); end
      1: begin r = (a - b + 16) % 16; c = (a < b); v = ((sa - sb) > 7) || ((sa - sb) < -8); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: begin r = (a * 2) % 16; c = (a >= 8); end
      default: begin r = a / 2; c = (a % 2) == 1; end
    endcase
    return {4'(r), c, v};
  endfunction

  // ALU under test: golden behaviour with an optional planted fault
  function automatic logic [5:0] alu_out(input int a, input int b, input int o,
                                         input int fm, input logic [255:0] m);
    logic [5:0] g;
    g = gold(a, b, o);
    case (fm)
      1: g[2] = 1'b0;
      2: g[1] = 1'b0;
      3: if (m[a*16 + b]) g[2] = ~g[2];
      default: ;
    endcase
    return g;
  endfunction

  always_comb begin
    {bus.alu_result, bus.alu_ccr} = alu_out(int'(bus.alu_n1), int'(bus.alu_n2),
                                            int'(bus.alu_op), fault_mode, fault_mask);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outcome of a whole sweep for the current fault setting
  task automatic model_sweep(input int o, output int e, output int f1, output int f2);
    e = 0; f1 = 0; f2 = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        if (alu_out(a, b, o, fault_mode, fault_mask) != gold(a, b, o)) begin
          if (e == 0) begin f1 = a; f2 = b; end
          e++;
        end
  endtask

  // Run one sweep; inject_at >= 0 pulses start (op=AND) at that busy cycle
  task automatic run_sweep(input string tag, input int o, input int exp_err,
                           input int exp_f1, input int exp_f2, input int inject_at);
    int k, idx, bad;
    @(negedge clk);
    start = 1'b1;
    op    = 3'(o);
    @(negedge clk);
    start = 1'b0;
    k = 0; bad = 0;
    while (busy && k < TIMEOUT) begin
      idx = k / (SC + 1);
      if (int'(bus.alu_n1) != (idx / 16) || int'(bus.alu_n2) != (idx % 16) ||
          int'(bus.alu_op) != o || done)
        bad++;
      start = (k == inject_at);
      op    = (k == inject_at) ? 3'b010 : 3'($urandom_range(0, 7));
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, k, BUSY_N);
    chk({tag, "_order"}, bad, 0);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_pass"}, int'(pass), int'(exp_err == 0));
    chk({tag, "_err_count"}, int'(err_count), exp_err);
    chk({tag, "_first_n1"}, int'(fe1), exp_f1);
    chk({tag, "_first_n2"}, int'(fe2), exp_f2);
    repeat (3) @(negedge clk);
    chk({tag, "_done_held"}, int'({done, busy}), 2);
  endtask

  initial begin
    int e, f1, f2, o, k;
    rst = 1'b1; start = 1'b0; op = 3'b000;
    fault_mode = 0; fault_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_flags", int'({busy, done, pass}), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_bus", int'({bus.alu_n1, bus.alu_n2, bus.alu_op}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start", int'({busy, done}), 0);

    fault_mode = 0;
    run_sweep("add_ok", 0, 0, 0, 0, -1);
    fault_mode = 1;
    run_sweep("add_r0_stuck", 0, 128, 0, 1, -1);
    fault_mode = 2;
    run_sweep("add_c_stuck", 0, 120, 1, 15, -1);
    fault_mode = 0;
    run_sweep("sub_ok", 1, 0, 0, 0, -1);
    run_sweep("add_ignore_start", 0, 0, 0, 0, 100);
    fault_mode = 3; fault_mask = '1;
    run_sweep("all_bad", int'($urandom_range(0, 7)), 256, 0, 0, -1);

    for (int it = 0; it < 4; it++) begin
      o = int'($urandom_range(0, 7));
      fault_mode = int'($urandom_range(0, 3));
      for (int w = 0; w < 8; w++) fault_mask[w*32 +: 32] = $urandom() & $urandom();
      model_sweep(o, e, f1, f2);
      run_sweep($sformatf("rand%0d", it), o, e, f1, f2, -1);
    end

    // Reset in the middle of a faulty sweep, then a clean re-sweep
    fault_mode = 3; fault_mask = '1;
    @(negedge clk);
    start = 1'b1; op = 3'b000;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(bus.alu_n1 == 4'd5 && bus.alu_n2 == 4'd3) && k < TIMEOUT) begin
      @(negedge clk);
      k++;
    end
    chk("reach_5_3", int'(k < TIMEOUT), 1);
    chk("pre_rst_err_nonzero", int'(err_count != 0), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_flags", int'({busy, done, pass}), 0);
    chk("midrst_err", int'(err_count), 0);
    chk("midrst_first", int'({fe1, fe2}), 0);
    chk("midrst_bus", int'({bus.alu_n1, bus.alu_n2, bus.alu_op}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", int'({busy, done}), 0);
    fault_mode = 0;
    run_sweep("resweep", 0, 0, 0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sweep_checker.md
ALU_SWEEP_CHECKER -- requirements
Module: alu_sweep_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, number of cycles operands are held before the ALU response is compared (legal 1..15).
REQ-002 SHALL have one clock and an asynchronous, active-high reset; all state SHALL change on the rising edge of clk except on reset assertion.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 start  in  1  single-cycle request to begin a sweep.
REQ-006 op  in  3  operator to sweep, latched on accepted start.
REQ-007 alu_n1, alu_n2  out  4 each  operands driven to the external ALU.
REQ-008 alu_op  out  3  operator driven to the external ALU.
REQ-009 alu_result  in  4  ALU result.
REQ-010 alu_ccr  in  2  ALU flags: bit1 carry, bit0 overflow.
REQ-011 busy  out  1  sweep in progress.
REQ-012 done  out  1  sweep finished, held until next accepted start.
REQ-013 pass  out  1  valid with done; 1 when err_count is 0.
REQ-014 err_count  out  9  number of mismatching vectors (0..256).
REQ-015 first_err_n1, first_err_n2  out  4 each  operands of the first mismatch, 0 if none.

Function
REQ-016 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT n1, 110 SHL n1 by 1, 111 SHR n1 by 1 (logical).
REQ-017 Golden result SHALL be 4-bit, modulo 16; ADD carry = bit 4 of n1+n2; SUB carry = borrow (n1<n2 unsigned); ADD/SUB overflow = two's-complement signed overflow; SHL carry = n1[3]; SHR carry = n1[0]; all other flags 0.
REQ-018 FSM states IDLE, SETTLE, CHECK, DONE; IDLE/DONE + start -> SETTLE with n1=n2=0, err_count cleared, first_err cleared, op latched.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then CHECK for one cycle comparing {alu_result, alu_ccr} with golden.
REQ-020 Mismatch in CHECK SHALL increment err_count; if err_count was 0, first_err_n1/n2 SHALL capture current operands.
REQ-021 Sweep order SHALL be n1 outer 0..15, n2 inner 0..15; after CHECK of (15,15) -> DONE, else advance operands and -> SETTLE.
REQ-022 Busy time SHALL be 256*(SETTLE_CYCLES+1) cycles; done SHALL rise the cycle after the last CHECK.
REQ-023 busy SHALL be 1 exactly in SETTLE and CHECK; done 1 exactly in DONE.
REQ-024 start while busy SHALL be ignored; op changes while busy SHALL not affect alu_op.
REQ-025 alu_n1, alu_n2, alu_op SHALL be registered outputs, stable through SETTLE and CHECK of a vector.
REQ-026 err_count SHALL not wrap; 256 mismatches report 256.

Reset
REQ-027 rst SHALL immediately force IDLE and all outputs to 0, including mid-sweep; no partial results retained.
REQ-028 After rst deassertion the block SHALL wait for a fresh start.

Structure
REQ-029 Opcode constants, CCR bit indices and state encoding SHALL live in shared package alu_pkg.
REQ-030 Golden model SHALL be a combinational sub-module alu_ref_model (n1, n2, op -> result, ccr), reusable by benches.

Verification
REQ-031 Correct ALU, op=ADD, SETTLE_CYCLES=1, start -> busy 512 cycles, done=1, pass=1, err_count=0, first_err=0/0.
REQ-032 ALU with alu_result[0] stuck 0, op=ADD -> err_count=128, first_err_n1=0, first_err_n2=1, pass=0.
REQ-033 ALU with carry stuck 0, op=ADD -> err_count=120, first_err_n1=1, first_err_n2=15.
REQ-034 Correct ALU, op=SUB, check vector (8,1) -> result 0111, ccr 01 accepted; sweep pass=1.
REQ-035 rst asserted at vector (5,3) -> all outputs 0 same cycle; new start re-sweeps from (0,0).
REQ-036 start pulsed with op=AND at cycle 100 of an ADD sweep -> ignored, alu_op stays 000, result identical to REQ-031.
